// File: rtl/timer_bus_master.sv
// Upstream requester for the timer peripheral: queues CPU register commands in a FIFO
// and issues them one at a time over req/gnt, returning read data or a timeout error.
module timer_bus_master #(
    parameter int P_ADDR_WIDTH   = 8,
    parameter int P_DATA_WIDTH   = 16,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [P_ADDR_WIDTH-1:0]           cmd_addr,
    input  logic [P_DATA_WIDTH-1:0]           cmd_wdata,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [P_DATA_WIDTH-1:0]           rsp_rdata,
    output logic                              rsp_err,
    output logic                              req,
    input  logic                              gnt,
    output logic [P_ADDR_WIDTH-1:0]           addr,
    output logic [P_DATA_WIDTH-1:0]           wdata,
    output logic                              write_en,
    input  logic [P_DATA_WIDTH-1:0]           rdata,
    output logic                              busy,
    output logic [$clog2(CMD_DEPTH+1)-1:0]    cmd_level
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int LVL_W = $clog2(CMD_DEPTH + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int ENT_W = 1 + P_ADDR_WIDTH + P_DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ENT_W-1:0]  fifo_mem [CMD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [ENT_W-1:0]  head;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              timeout_hit;
    logic [CNT_W-1:0]  tmo_cnt;

    assign fifo_empty = (cmd_level == '0);
    assign fifo_full  = (cmd_level == LVL_W'(CMD_DEPTH));
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[rd_ptr];

    // Command storage carries no reset; only pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cmd_level <= cmd_level + LVL_W'(1);
                2'b01:   cmd_level <= cmd_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (gnt || timeout_hit) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop         = 1'b0;
        timeout_hit = 1'b0;
        busy        = 1'b0;
        pop         = (state == S_IDLE) && !fifo_empty;
        timeout_hit = (state == S_REQ) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
        busy        = (state != S_IDLE) || !fifo_empty;
    end

    // Peripheral-side and response outputs are all flops; gnt wins over a same-cycle timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            req       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            write_en  <= 1'b0;
            tmo_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {write_en, addr, wdata} <= head;
                        req     <= 1'b1;
                        tmo_cnt <= '0;
                    end
                end
                S_REQ: begin
                    if (gnt) begin
                        rsp_rdata <= write_en ? '0 : rdata;
                        rsp_err   <= 1'b0;
                        req       <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else if (timeout_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        req       <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
